// File: rtl/aux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aux_port_arbiter
// Description : Single-port aux buffer RAM arbiter; reads always win, writes
//               queue in a FIFO with newest-match read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module aux_port_arbiter #(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         rd_req_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] rd_address_in,
    output logic                         rd_valid_out,
    output logic [DATA_WIDTH-1:0]        rd_data_out,
    input  logic                         wr_req_in,
    input  logic [AUX_ADDRESS_WIDTH-1:0] wr_address_in,
    input  logic [DATA_WIDTH-1:0]        wr_data_in,
    output logic                         wr_ready_out,
    output logic [AUX_ADDRESS_WIDTH-1:0] ram_address_out,
    output logic [DATA_WIDTH-1:0]        ram_data_out,
    output logic                         ram_wr_out,
    input  logic [DATA_WIDTH-1:0]        ram_data_in,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_out
);

    localparam int                       c_PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int                       c_LEVEL_WIDTH = c_PTR_WIDTH + 1;
    localparam logic [c_LEVEL_WIDTH-1:0] c_FULL_LEVEL  = c_LEVEL_WIDTH'(FIFO_DEPTH);

    // Bit 0 marks a read issue, bit 1 a RAM write; each is used directly as a flop output.
    localparam logic [1:0] c_GRANT_IDLE  = 2'b00;
    localparam logic [1:0] c_GRANT_READ  = 2'b01;
    localparam logic [1:0] c_GRANT_WRITE = 2'b10;

    logic [AUX_ADDRESS_WIDTH-1:0] r_fifo_address [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]        r_fifo_data    [FIFO_DEPTH];
    logic [c_PTR_WIDTH-1:0]       r_wr_ptr;
    logic [c_PTR_WIDTH-1:0]       r_rd_ptr;
    logic [c_LEVEL_WIDTH-1:0]     r_level;

    logic                         w_push;
    logic                         w_pop;
    logic [FIFO_DEPTH-1:0]        w_entry_hit;
    logic                         w_fwd_hit;
    logic [DATA_WIDTH-1:0]        w_fwd_data;

    logic [1:0]                   r_grant;
    logic [1:0]                   w_grant_next;
    logic [AUX_ADDRESS_WIDTH-1:0] w_ram_address_next;
    logic [DATA_WIDTH-1:0]        w_ram_data_next;

    logic                         r_p1_fwd;
    logic [DATA_WIDTH-1:0]        r_p1_fwd_data;
    logic                         r_p2_valid;
    logic                         r_p2_fwd;
    logic [DATA_WIDTH-1:0]        r_p2_fwd_data;

    assign wr_ready_out   = reset_n_in & (r_level < c_FULL_LEVEL);
    assign w_push         = wr_req_in & wr_ready_out;
    assign fifo_level_out = r_level;
    assign ram_wr_out     = r_grant[1];

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (w_push) begin
            r_fifo_address[r_wr_ptr] <= wr_address_in;
            r_fifo_data[r_wr_ptr]    <= wr_data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: hit on any live entry; age is distance from the head
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [c_PTR_WIDTH-1:0] w_age;
            assign w_age           = c_PTR_WIDTH'(gi) - r_rd_ptr;
            assign w_entry_hit[gi] = ({1'b0, w_age} < r_level) &&
                                     (r_fifo_address[gi] == rd_address_in);
        end
    endgenerate

    // Walk oldest to newest so the newest matching entry is the one kept.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (w_entry_hit[r_rd_ptr + c_PTR_WIDTH'(k)]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[r_rd_ptr + c_PTR_WIDTH'(k)];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_grant         <= c_GRANT_IDLE;
            ram_address_out <= '0;
            ram_data_out    <= '0;
        end else begin
            r_grant         <= w_grant_next;
            ram_address_out <= w_ram_address_next;
            ram_data_out    <= w_ram_data_next;
        end
    end

    always_comb begin
        w_grant_next = c_GRANT_IDLE;
        if (rd_req_in) begin
            w_grant_next = c_GRANT_READ;
        end else if (r_level != '0) begin
            w_grant_next = c_GRANT_WRITE;
        end
    end

    always_comb begin
        w_pop              = 1'b0;
        w_ram_address_next = ram_address_out;
        w_ram_data_next    = ram_data_out;
        case (w_grant_next)
            c_GRANT_READ: begin
                w_ram_address_next = rd_address_in;
            end
            c_GRANT_WRITE: begin
                w_pop              = 1'b1;
                w_ram_address_next = r_fifo_address[r_rd_ptr];
                w_ram_data_next    = r_fifo_data[r_rd_ptr];
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read pipeline: issue -> RAM access -> output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_p1_fwd      <= 1'b0;
            r_p1_fwd_data <= '0;
            r_p2_valid    <= 1'b0;
            r_p2_fwd      <= 1'b0;
            r_p2_fwd_data <= '0;
            rd_valid_out  <= 1'b0;
            rd_data_out   <= '0;
        end else begin
            r_p1_fwd      <= w_fwd_hit & rd_req_in;
            r_p1_fwd_data <= w_fwd_data;
            r_p2_valid    <= r_grant[0];
            r_p2_fwd      <= r_p1_fwd;
            r_p2_fwd_data <= r_p1_fwd_data;
            rd_valid_out  <= r_p2_valid;
            if (r_p2_valid) begin
                rd_data_out <= r_p2_fwd ? r_p2_fwd_data : ram_data_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aux_port_arbiter
// Description : Directed self-checking bench for aux_port_arbiter with a
//               one-cycle-latency RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aux_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int FD = 4;

    logic          clock_in = 1'b0;
    logic          reset_n_in;
    logic          rd_req_in;
    logic [AW-1:0] rd_address_in;
    logic          rd_valid_out;
    logic [DW-1:0] rd_data_out;
    logic          wr_req_in;
    logic [AW-1:0] wr_address_in;
    logic [DW-1:0] wr_data_in;
    logic          wr_ready_out;
    logic [AW-1:0] ram_address_out;
    logic [DW-1:0] ram_data_out;
    logic          ram_wr_out;
    logic [DW-1:0] ram_data_in = '0;
    logic [2:0]    fifo_level_out;

    int n_asserts = 0;
    int n_fails   = 0;

    aux_port_arbiter #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .FIFO_DEPTH        (FD)
    ) dut (
        .clock_in        (clock_in),
        .reset_n_in      (reset_n_in),
        .rd_req_in       (rd_req_in),
        .rd_address_in   (rd_address_in),
        .rd_valid_out    (rd_valid_out),
        .rd_data_out     (rd_data_out),
        .wr_req_in       (wr_req_in),
        .wr_address_in   (wr_address_in),
        .wr_data_in      (wr_data_in),
        .wr_ready_out    (wr_ready_out),
        .ram_address_out (ram_address_out),
        .ram_data_out    (ram_data_out),
        .ram_wr_out      (ram_wr_out),
        .ram_data_in     (ram_data_in),
        .fifo_level_out  (fifo_level_out)
    );

    always #5 clock_in = ~clock_in;

    // RAM model: preset contents until an address is first written.
    bit [DW-1:0] mem [32];
    bit [31:0]   written;

    function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
        case (a)
            5'd7:    return 16'h1234;
            5'd8:    return 16'h5678;
            5'd9:    return 16'h9ABC;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clock_in) begin
        ram_data_in <= written[ram_address_out] ? mem[ram_address_out] : preset(ram_address_out);
        if (ram_wr_out) begin
            mem[ram_address_out]     <= ram_data_out;
            written[ram_address_out] <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with both requesters active
        reset_n_in    = 1'b0;
        rd_req_in     = 1'b1;
        rd_address_in = 5'd7;
        wr_req_in     = 1'b1;
        wr_address_in = 5'd1;
        wr_data_in    = 16'h5555;
        #1;
        check("rst_wr_ready_comb", wr_ready_out, 0);
        repeat (4) tick();
        check("rst_rd_valid", rd_valid_out, 0);
        check("rst_rd_data", rd_data_out, 0);
        check("rst_ram_addr", ram_address_out, 0);
        check("rst_ram_data", ram_data_out, 0);
        check("rst_ram_wr", ram_wr_out, 0);
        check("rst_level", fifo_level_out, 0);
        check("rst_wr_ready", wr_ready_out, 0);

        reset_n_in = 1'b1;
        rd_req_in  = 1'b0;
        wr_req_in  = 1'b0;
        #1;
        check("post_rst_wr_ready", wr_ready_out, 1);

        // Single write, no reads
        wr_req_in     = 1'b1;
        wr_address_in = 5'd3;
        wr_data_in    = 16'hBEEF;
        tick();
        wr_req_in = 1'b0;
        check("wr1_level_after_push", fifo_level_out, 1);
        check("wr1_no_wr_yet", ram_wr_out, 0);
        tick();
        check("wr1_ram_wr", ram_wr_out, 1);
        check("wr1_ram_addr", ram_address_out, 3);
        check("wr1_ram_data", ram_data_out, 16'hBEEF);
        check("wr1_level_after_pop", fifo_level_out, 0);
        tick();
        check("wr1_idle_wr", ram_wr_out, 0);
        check("wr1_idle_addr_hold", ram_address_out, 3);

        // Back-to-back reads 7, 8, 9 from RAM
        rd_req_in     = 1'b1;
        rd_address_in = 5'd7;
        tick();
        check("rd_lat_no_early_valid", rd_valid_out, 0);
        check("rd_ram_addr", ram_address_out, 7);
        rd_address_in = 5'd8;
        tick();
        check("rd_lat_no_valid_t1", rd_valid_out, 0);
        rd_address_in = 5'd9;
        tick();
        check("rd7_valid", rd_valid_out, 1);
        check("rd7_data", rd_data_out, 16'h1234);
        rd_req_in = 1'b0;
        tick();
        check("rd8_valid", rd_valid_out, 1);
        check("rd8_data", rd_data_out, 16'h5678);
        tick();
        check("rd9_valid", rd_valid_out, 1);
        check("rd9_data", rd_data_out, 16'h9ABC);
        tick();
        check("rd_valid_drop", rd_valid_out, 0);

        // Fill the queue under continuous reads; fifth write refused
        rd_req_in     = 1'b1;
        rd_address_in = 5'd20;
        wr_req_in     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_address_in = AW'(10 + i);
            wr_data_in    = DW'(16'h1010 + i * 16'h0101);
            check("fill_wr_ready", wr_ready_out, 1);
            tick();
            check("fill_level", fifo_level_out, i + 1);
            check("fill_no_ram_wr", ram_wr_out, 0);
        end
        check("full_wr_ready", wr_ready_out, 0);
        wr_address_in = 5'd14;
        wr_data_in    = 16'h1414;
        tick();
        check("full_level_hold", fifo_level_out, 4);
        check("full_wr_ready_hold", wr_ready_out, 0);
        check("full_starved", ram_wr_out, 0);
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_wr", ram_wr_out, 1);
            check("drain_addr", ram_address_out, 10 + i);
            check("drain_data", ram_data_out, 16'h1010 + i * 16'h0101);
            check("drain_level", fifo_level_out, 3 - i);
        end
        tick();
        check("drain_done_wr", ram_wr_out, 0);

        // Forwarding: AAAA then BBBB to addr 5 queued under reads
        rd_req_in     = 1'b1;
        rd_address_in = 5'd21;
        wr_req_in     = 1'b1;
        wr_address_in = 5'd5;
        wr_data_in    = 16'hAAAA;
        tick();
        wr_data_in = 16'hBBBB;
        tick();
        check("fwd_level2", fifo_level_out, 2);
        rd_address_in = 5'd5;
        wr_req_in     = 1'b0;
        tick();
        wr_req_in  = 1'b1;
        wr_data_in = 16'hCCCC;
        tick();
        wr_req_in = 1'b0;
        tick();
        check("fwd_newest_valid", rd_valid_out, 1);
        check("fwd_newest_data", rd_data_out, 16'hBBBB);
        check("fwd_level3", fifo_level_out, 3);
        rd_req_in = 1'b0;
        tick();
        check("fwd_same_cycle_valid", rd_valid_out, 1);
        check("fwd_same_cycle_data", rd_data_out, 16'hBBBB);
        check("fwd_drain_a", ram_data_out, 16'hAAAA);
        tick();
        check("fwd_later_valid", rd_valid_out, 1);
        check("fwd_later_data", rd_data_out, 16'hCCCC);
        check("fwd_drain_b", ram_data_out, 16'hBBBB);
        tick();
        check("fwd_drain_c_wr", ram_wr_out, 1);
        check("fwd_drain_c", ram_data_out, 16'hCCCC);
        check("fwd_drain_level", fifo_level_out, 0);
        check("fwd_no_extra_valid", rd_valid_out, 0);
        tick();
        rd_req_in = 1'b1;
        tick();
        rd_req_in = 1'b0;
        tick();
        tick();
        check("ram_final_valid", rd_valid_out, 1);
        check("ram_final_data", rd_data_out, 16'hCCCC);

        // Reset with 3 queued writes and reads in flight
        rd_req_in     = 1'b1;
        rd_address_in = 5'd7;
        wr_req_in     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_address_in = AW'(25 + i);
            wr_data_in    = DW'(i + 1);
            tick();
        end
        wr_req_in = 1'b0;
        tick();
        check("pre_rst_level", fifo_level_out, 3);
        check("pre_rst_valid", rd_valid_out, 1);
        reset_n_in = 1'b0;
        rd_req_in  = 1'b0;
        tick();
        check("mid_rst_valid", rd_valid_out, 0);
        check("mid_rst_data", rd_data_out, 0);
        check("mid_rst_ram_wr", ram_wr_out, 0);
        check("mid_rst_ram_addr", ram_address_out, 0);
        check("mid_rst_level", fifo_level_out, 0);
        check("mid_rst_wr_ready", wr_ready_out, 0);
        reset_n_in = 1'b1;
        tick();
        check("post_rst_valid", rd_valid_out, 0);
        check("post_rst_ram_wr", ram_wr_out, 0);
        check("post_rst_level", fifo_level_out, 0);
        check("post_rst_ready", wr_ready_out, 1);
        tick();
        check("post_rst_valid2", rd_valid_out, 0);
        check("post_rst_ram_wr2", ram_wr_out, 0);
        check("discarded_writes", {29'd0, written[27], written[26], written[25]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
